// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: issues data-memory requests with byte lanes, extends loads and returns a registered writeback packet.
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned accesses instead of issuing them.
module mem_access_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mem_r,
  input  logic            in_mem_w,
  input  logic            in_mem_to_reg,
  input  logic            in_reg_w,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  output logic            out_reg_w,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_misalign
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUS  = 1'b1;

  logic [0:0]      state;
  logic [XLEN-1:0] addr_p0;
  logic [XLEN-1:0] wdata_p0;
  logic [2:0]      funct3_p0;
  logic [4:0]      rd_p0;
  logic            reg_w_p0;
  logic            store_p0;

  logic            accept;
  logic            is_mem;
  logic            misaligned;
  logic            in_bus;
  logic            unused_ok;

  function automatic logic [7:0] strobe_lanes(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] mask;
    case (size)
      2'd0:    mask = 16'h0001;
      2'd1:    mask = 16'h0003;
      2'd2:    mask = 16'h000F;
      default: mask = 16'h00FF;
    endcase
    mask = mask << off;
    return mask[7:0];
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] funct3, input logic [2:0] off,
                                                  input logic [XLEN-1:0] raw);
    logic        [XLEN-1:0] lane;
    logic signed [XLEN-1:0] ext;
    lane = raw >> {off, 3'b000};
    case (funct3)
      3'b000:  ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  ext = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}}, lane[15:0]};
      3'b110:  ext = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: ext = lane;
    endcase
    return ext;
  endfunction

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign is_mem    = in_mem_r || in_mem_w;
  assign in_bus    = (state == BUS);
  // mem_to_reg adds nothing here: a load always writes back its extended value.
  assign unused_ok = &{1'b0, in_mem_to_reg};

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    case (in_funct3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = in_addr[0];
      2'd2:    misaligned = |in_addr[1:0];
      default: misaligned = |in_addr[2:0];
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Request bus is driven only while BUS, so outputs read 0 out of reset.
  assign dreq_valid  = in_bus;
  assign dreq_addr   = in_bus ? addr_p0 : '0;
  assign dreq_size   = in_bus ? {1'b0, funct3_p0[1:0]} : 3'd0;
  assign dreq_strobe = (in_bus && store_p0) ? strobe_lanes(funct3_p0[1:0], addr_p0[2:0]) : 8'd0;
  assign dreq_data   = (in_bus && store_p0) ? (wdata_p0 << {addr_p0[2:0], 3'b000}) : '0;

  // p0: latched instruction held stable for the duration of the bus access
  always_ff @(posedge clk) begin
    if (accept && is_mem && !misaligned) begin
      addr_p0   <= in_addr;
      wdata_p0  <= in_wdata;
      funct3_p0 <= in_funct3;
      rd_p0     <= in_rd;
      reg_w_p0  <= in_reg_w;
      store_p0  <= in_mem_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      out_reg_w    <= 1'b0;
      out_rd       <= 5'd0;
      out_result   <= '0;
      out_misalign <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              out_valid    <= 1'b1;
              out_reg_w    <= in_reg_w;
              out_rd       <= in_rd;
              out_result   <= in_addr;
              out_misalign <= 1'b0;
            end else if (misaligned) begin
              out_valid    <= 1'b1;
              out_reg_w    <= 1'b0;
              out_rd       <= in_rd;
              out_result   <= in_addr;
              out_misalign <= 1'b1;
            end else begin
              state <= BUS;
            end
          end
        end
        default: begin
          if (dresp_data_ok) begin
            out_valid    <= 1'b1;
            out_reg_w    <= store_p0 ? 1'b0 : reg_w_p0;
            out_rd       <= rd_p0;
            out_result   <= store_p0 ? '0 : load_extend(funct3_p0, addr_p0[2:0], dresp_data);
            out_misalign <= 1'b0;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit with a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_mem_r, in_mem_w, in_mem_to_reg, in_reg_w;
  logic [2:0]  in_funct3;
  logic [63:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        out_valid, out_reg_w, out_misalign;
  logic [4:0]  out_rd;
  logic [63:0] out_result;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic        reg_w;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        mis;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mem_access_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_r(in_mem_r), .in_mem_w(in_mem_w), .in_mem_to_reg(in_mem_to_reg), .in_reg_w(in_reg_w),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_reg_w(out_reg_w), .out_rd(out_rd),
    .out_result(out_result), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: works byte by byte, bytes landing past lane 7 are lost.
  function automatic logic [7:0] m_strobe(input int size, input int off);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < (1 << size); i++)
      if (off + i < 8) s[off + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] wd, input int off);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < 8; i++)
      if (off + i < 8) r[8*(off+i) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input int off, input logic [63:0] d);
    int n = 1 << f3[1:0];
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*i +: 8] = d[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) v = v - (64'd1 << (8*n));
    return v;
  endfunction

  function automatic bit m_misaligned(input logic [63:0] addr, input int size);
`ifdef MEM_MISALIGN_CHECK_EN
    return (addr % (64'd1 << size)) != 64'd0;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_cycle", 64'(cyc), 64'(e.cyc));
        check("out_reg_w", 64'(out_reg_w), 64'(e.reg_w));
        check("out_rd", 64'(out_rd), 64'(e.rd));
        check("out_result", out_result, e.result);
        check("out_misalign", 64'(out_misalign), 64'(e.mis));
      end
    end
  end

  task automatic run_instr(input bit mr, input bit mw, input bit rw, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                           input int delay, input logic [63:0] rdata, input bit idle_pulse);
    bit   is_mem, mis;
    int   size, off;
    exp_t e;
    is_mem = mr || mw;
    size   = mw ? int'(f3[1:0]) : int'(f3[1:0]);
    off    = int'(addr[2:0]);
    mis    = is_mem && m_misaligned(addr, size);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_mem_r = mr; in_mem_w = mw; in_reg_w = rw; in_mem_to_reg = mr;
    in_funct3 = f3; in_addr = addr; in_wdata = wd; in_rd = rd;
    dresp_data_ok = idle_pulse; dresp_data = {$urandom(), $urandom()};
    if (!is_mem || mis) begin
      e.reg_w = is_mem ? 1'b0 : rw; e.rd = rd; e.result = addr; e.mis = mis; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; dresp_data_ok = 1'b0;
    if (is_mem && !mis) begin
      check("dreq_valid_start", 64'(dreq_valid), 64'd1);
      check("dreq_addr", dreq_addr, addr);
      check("dreq_size", 64'(dreq_size), 64'(size));
      check("dreq_strobe", 64'(dreq_strobe), mw ? 64'(m_strobe(size, off)) : 64'd0);
      if (mw) check("dreq_data", dreq_data, m_wdata(wd, off));
      for (int k = 0; k < delay; k++) begin
        @(negedge clk);
        in_valid = $urandom_range(0, 1) != 0; in_mem_r = 1'b0; in_mem_w = 1'b0;
        in_addr = {$urandom(), $urandom()}; in_rd = 5'($urandom());
        check("in_ready_bus", 64'(in_ready), 64'd0);
        check("dreq_addr_stable", dreq_addr, addr);
        check("dreq_valid_hold", 64'(dreq_valid), 64'd1);
      end
      @(negedge clk);
      in_valid = 1'b0; dresp_data_ok = 1'b1; dresp_data = rdata;
      e.reg_w = mw ? 1'b0 : rw; e.rd = rd; e.result = mw ? 64'd0 : m_load(f3, off, rdata);
      e.mis = 1'b0; e.cyc = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      dresp_data_ok = 1'b0; dresp_data = {$urandom(), $urandom()};
      check("dreq_valid_end", 64'(dreq_valid), 64'd0);
    end else begin
      check("dreq_valid_none", 64'(dreq_valid), 64'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_mem_r = 1'b0; in_mem_w = 1'b0; in_mem_to_reg = 1'b0;
    in_reg_w = 1'b0; in_funct3 = 3'd0; in_addr = 64'd0; in_wdata = 64'd0; in_rd = 5'd0;
    dresp_data_ok = 1'b0; dresp_data = 64'd0;
    #12;
    check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_dreq_strobe", 64'(dreq_strobe), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); reset = 1'b1;

    // Directed cases from the test plan.
    run_instr(0, 0, 1, 3'b000, 64'h1234, 64'd0, 5'd5, 0, 64'd0, 0);
    run_instr(1, 0, 1, 3'b000, 64'h1003, 64'd0, 5'd7, 3, 64'h00000000_80000000, 0);
    run_instr(0, 1, 1, 3'b001, 64'h2006, 64'hBEEF, 5'd9, 1, 64'd0, 0);
    run_instr(1, 0, 1, 3'b110, 64'h4, 64'd0, 5'd10, 0, 64'hFFFFFFFF_00000000, 0);
    run_instr(1, 0, 1, 3'b011, 64'h8, 64'd0, 5'd11, 2, 64'h01234567_89ABCDEF, 0);
    run_instr(1, 0, 1, 3'b010, 64'h2, 64'd0, 5'd12, 1, 64'hCAFEF00D_DEADBEEF, 0);
    run_instr(1, 1, 1, 3'b011, 64'h10, 64'h55AA55AA_55AA55AA, 5'd13, 0, 64'd0, 0);

    for (int n = 0; n < 300; n++) begin
      int kind; bit mr, mw; logic [2:0] f3; logic [63:0] a;
      kind = $urandom_range(0, 2);
      mw = (kind == 2);
      mr = (kind == 1) || (mw && $urandom_range(0, 1) != 0);
      f3 = mw ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a  = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      run_instr(mr, mw, $urandom_range(0, 1) != 0, f3, a, {$urandom(), $urandom()},
                5'($urandom()), $urandom_range(0, 3), {$urandom(), $urandom()},
                $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of a bus access abandons it.
    @(negedge clk);
    in_valid = 1'b1; in_mem_r = 1'b1; in_mem_w = 1'b0; in_funct3 = 3'b011;
    in_addr = 64'h40; in_rd = 5'd3; in_reg_w = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    check("midbus_dreq_valid", 64'(dreq_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("midbus_rst_dreq_valid", 64'(dreq_valid), 64'd0);
    check("midbus_rst_out_valid", 64'(out_valid), 64'd0);
    check("midbus_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); dresp_data_ok = 1'b1;
    @(posedge clk); #1; dresp_data_ok = 1'b0;
    check("late_ok_out_valid", 64'(out_valid), 64'd0);
    check("late_ok_dreq_valid", 64'(dreq_valid), 64'd0);

    // Reset while a writeback is presented clears out_valid at once.
    @(negedge clk);
    in_valid = 1'b1; in_mem_r = 1'b0; in_mem_w = 1'b0; in_addr = 64'h77; in_rd = 5'd1;
    @(posedge clk); #1; in_valid = 1'b0;
    check("wb_before_rst", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("wb_rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk); sb.delete(); reset = 1'b1;

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
